// File: rtl/regfile_wb_sched_if.sv
// Bundles the issue-stage hazard port, both writeback requesters and the
// register-file write port of the writeback scheduler.
interface regfile_wb_sched_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic              iss_valid;
  logic [AWIDTH-1:0] iss_rs1;
  logic [AWIDTH-1:0] iss_rs2;
  logic [AWIDTH-1:0] iss_rd;
  logic              iss_wr;
  logic              iss_stall;

  logic              wb0_valid;
  logic [AWIDTH-1:0] wb0_addr;
  logic [DWIDTH-1:0] wb0_data;
  logic              wb0_ready;
  logic              wb1_valid;
  logic [AWIDTH-1:0] wb1_addr;
  logic [DWIDTH-1:0] wb1_data;
  logic              wb1_ready;

  logic              rf_wr;
  logic [AWIDTH-1:0] rf_waddr;
  logic [DWIDTH-1:0] rf_wdata;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    input  iss_stall, wb0_ready, wb1_ready, rf_wr, rf_waddr, rf_wdata
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
    input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    output iss_stall, wb0_ready, wb1_ready, rf_wr, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin writeback arbiter (port 0 = ALU, port 1 = LSU) onto the single
// register-file write port, plus a pending-write scoreboard driving iss_stall.
module regfile_wb_sched #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter int REG_CNT = 32
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_sched_if.slave bus
);

  logic [REG_CNT-1:0] pending_q, pending_d;
  logic               prio_q, prio_d;
  logic               rf_wr_q, rf_wr_d;
  logic [AWIDTH-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DWIDTH-1:0]  rf_wdata_q, rf_wdata_d;

  logic               gnt0, gnt1, gnt_any;
  logic [AWIDTH-1:0]  gnt_addr;
  logic [DWIDTH-1:0]  gnt_data;
  logic               stall;
  logic               issue_fire;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = bus.wb0_valid & (~bus.wb1_valid | ~prio_q);
      gnt1 = bus.wb1_valid & (~bus.wb0_valid |  prio_q);
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign gnt_addr = gnt1 ? bus.wb1_addr : bus.wb0_addr;
  assign gnt_data = gnt1 ? bus.wb1_data : bus.wb0_data;

  // pending_q[0] is held at 0, so a zero index never contributes a hazard
  assign stall = ~rst & bus.iss_valid &
                 (pending_q[bus.iss_rs1] | pending_q[bus.iss_rs2] |
                  (bus.iss_wr & pending_q[bus.iss_rd]));

  assign issue_fire = bus.iss_valid & ~stall & bus.iss_wr & (bus.iss_rd != '0);

  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;

    rf_wr_d    = gnt_any & (gnt_addr != '0);
    rf_waddr_d = gnt_any ? gnt_addr : rf_waddr_q;
    rf_wdata_d = gnt_any ? gnt_data : rf_wdata_q;

    // clear first so a same-cycle set on the same register wins
    pending_d = pending_q;
    if (rf_wr_q)    pending_d[rf_waddr_q] = 1'b0;
    if (issue_fire) pending_d[bus.iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      prio_q     <= 1'b0;
      rf_wr_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      pending_q  <= pending_d;
      prio_q     <= prio_d;
      rf_wr_q    <= rf_wr_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.iss_stall = stall;
  assign bus.wb0_ready = gnt0;
  assign bus.wb1_ready = gnt1;
  assign bus.rf_wr     = rf_wr_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed and random checks of regfile_wb_sched against a behavioural model
// of the round-robin arbiter, output stage and scoreboard.
module tb_regfile_wb_sched;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;

  regfile_wb_sched_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  regfile_wb_sched #(.DWIDTH(DW), .AWIDTH(AW), .REG_CNT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit          m_pend [0:31];
  bit          m_pref;            // port that wins when both request
  bit          m_rf_wr;
  bit [AW-1:0] m_waddr;
  bit [DW-1:0] m_wdata;
  bit          m_g0, m_g1;
  logic        obs_r0, obs_r1, obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.iss_valid = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0; bus.iss_wr = 0;
    bus.wb0_valid = 0; bus.wb0_addr = 0; bus.wb0_data = 0;
    bus.wb1_valid = 0; bus.wb1_addr = 0; bus.wb1_data = 0;
  endtask

  // Inputs are set by the caller just after a falling edge.
  task automatic cycle(input bit r);
    bit xs, fire;
    bit [AW-1:0] a;
    bit [DW-1:0] d;
    rst = r;
    #1;
    m_g0 = 0; m_g1 = 0;
    if (!r) begin
      if (bus.wb0_valid && bus.wb1_valid) begin
        if (m_pref) m_g1 = 1; else m_g0 = 1;
      end else begin
        m_g0 = bus.wb0_valid;
        m_g1 = bus.wb1_valid;
      end
    end
    xs = !r && bus.iss_valid &&
         ((bus.iss_rs1 != 0 && m_pend[bus.iss_rs1]) ||
          (bus.iss_rs2 != 0 && m_pend[bus.iss_rs2]) ||
          (bus.iss_wr && bus.iss_rd != 0 && m_pend[bus.iss_rd]));
    fire = !r && bus.iss_valid && !xs && bus.iss_wr && bus.iss_rd != 0;
    obs_r0 = bus.wb0_ready; obs_r1 = bus.wb1_ready; obs_stall = bus.iss_stall;
    check("wb0_ready", {31'b0, obs_r0}, {31'b0, m_g0});
    check("wb1_ready", {31'b0, obs_r1}, {31'b0, m_g1});
    check("iss_stall", {31'b0, obs_stall}, {31'b0, xs});
    a = m_g1 ? bus.wb1_addr : bus.wb0_addr;
    d = m_g1 ? bus.wb1_data : bus.wb0_data;
    @(posedge clk);
    if (r) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_pref = 0; m_rf_wr = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      if (m_rf_wr) m_pend[m_waddr] = 0;
      if (fire) m_pend[bus.iss_rd] = 1;
      if (m_g0 || m_g1) begin
        m_rf_wr = (a != 0);
        m_waddr = a;
        m_wdata = d;
        m_pref  = m_g0;
      end else begin
        m_rf_wr = 0;
      end
    end
    #1;
    check("rf_wr", {31'b0, bus.rf_wr}, {31'b0, m_rf_wr});
    if (m_rf_wr || r) begin
      check("rf_waddr", {27'b0, bus.rf_waddr}, {27'b0, m_waddr});
      check("rf_wdata", bus.rf_wdata, m_wdata);
    end
    @(negedge clk);
  endtask

  bit h0, h1;

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);

    // reset held with everything asserted
    bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rd = 2; bus.iss_rs1 = 2;
    bus.wb0_valid = 1; bus.wb0_addr = 3; bus.wb0_data = 32'h1111_0003;
    bus.wb1_valid = 1; bus.wb1_addr = 7; bus.wb1_data = 32'h2222_0007;
    cycle(1);
    cycle(1);
    check("rst_rf_wr", {31'b0, bus.rf_wr}, 32'd0);
    check("rst_stall", {31'b0, obs_stall}, 32'd0);
    bus.iss_valid = 0;

    // contention: p0, p1, p0, p1
    cycle(0);
    check("first_grant_p0", {31'b0, obs_r0}, 32'd1);
    check("cont_waddr0", {27'b0, bus.rf_waddr}, 32'd3);
    cycle(0);
    check("cont_grant_p1", {31'b0, obs_r1}, 32'd1);
    check("cont_waddr1", {27'b0, bus.rf_waddr}, 32'd7);
    cycle(0);
    check("cont_waddr2", {27'b0, bus.rf_waddr}, 32'd3);
    cycle(0);
    check("cont_waddr3", {27'b0, bus.rf_waddr}, 32'd7);

    // single write on port 0
    idle_inputs();
    bus.wb0_valid = 1; bus.wb0_addr = 5; bus.wb0_data = 32'hDEAD_BEEF;
    cycle(0);
    check("single_ready", {31'b0, obs_r0}, 32'd1);
    check("single_rf_wr", {31'b0, bus.rf_wr}, 32'd1);
    check("single_rf_data", bus.rf_wdata, 32'hDEAD_BEEF);
    idle_inputs();
    cycle(0);
    check("single_rf_wr_drop", {31'b0, bus.rf_wr}, 32'd0);

    // x0 write on port 1 consumes the grant, priority returns to port 0
    bus.wb1_valid = 1; bus.wb1_addr = 0; bus.wb1_data = 32'h5555_AAAA;
    cycle(0);
    check("x0_ready", {31'b0, obs_r1}, 32'd1);
    check("x0_rf_wr", {31'b0, bus.rf_wr}, 32'd0);
    bus.wb0_valid = 1; bus.wb0_addr = 6; bus.wb0_data = 32'h6;
    bus.wb1_addr = 8; bus.wb1_data = 32'h8;
    cycle(0);
    check("x0_prio_p0", {31'b0, obs_r0}, 32'd1);
    idle_inputs();
    cycle(0);

    // RAW on x9
    bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rd = 9;
    cycle(0);
    bus.iss_wr = 0; bus.iss_rd = 0; bus.iss_rs1 = 9;
    cycle(0);
    check("raw_stall_m1", {31'b0, obs_stall}, 32'd1);
    cycle(0);
    bus.wb0_valid = 1; bus.wb0_addr = 9; bus.wb0_data = 32'h0000_0099;
    cycle(0);
    bus.wb0_valid = 0;
    cycle(0);
    check("raw_stall_k1", {31'b0, obs_stall}, 32'd1);
    cycle(0);
    check("raw_stall_k2", {31'b0, obs_stall}, 32'd0);

    // WAW on x4, then reset clears the scoreboard
    idle_inputs();
    bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rd = 4;
    cycle(0);
    cycle(0);
    check("waw_stall", {31'b0, obs_stall}, 32'd1);
    cycle(1);
    check("waw_rst_stall", {31'b0, obs_stall}, 32'd0);
    cycle(0);
    check("waw_after_rst", {31'b0, obs_stall}, 32'd0);
    idle_inputs();
    cycle(0);

    // random traffic; requesters hold until accepted
    h0 = 0; h1 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!h0) begin
        bus.wb0_valid = 1'($urandom_range(0, 1));
        bus.wb0_addr  = 5'($urandom_range(0, 7));
        bus.wb0_data  = $urandom;
      end
      if (!h1) begin
        bus.wb1_valid = 1'($urandom_range(0, 1));
        bus.wb1_addr  = 5'($urandom_range(0, 7));
        bus.wb1_data  = $urandom;
      end
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_wr    = 1'($urandom_range(0, 1));
      bus.iss_rs1   = 5'($urandom_range(0, 7));
      bus.iss_rs2   = 5'($urandom_range(0, 7));
      bus.iss_rd    = 5'($urandom_range(0, 7));
      cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      h0 = bus.wb0_valid && !m_g0;
      h1 = bus.wb1_valid && !m_g1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
